// File: rtl/rvfi_trace_buffer_if.sv
// RVFI retirement input bus plus the trace record output bus with its valid/ready handshake.
// The slave modport is the trace buffer; the master modport is the core/consumer side.
interface rvfi_trace_buffer_if;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;

  logic        trace_valid_o;
  logic        trace_ready_i;
  logic [63:0] trace_order_o;
  logic [31:0] trace_insn_o;
  logic        trace_trap_o;
  logic [31:0] trace_pc_rdata_o;
  logic [31:0] trace_pc_wdata_o;
  logic [4:0]  trace_rd_addr_o;
  logic [31:0] trace_rd_wdata_o;

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rd_addr, rvfi_rd_wdata, trace_ready_i,
    output trace_valid_o, trace_order_o, trace_insn_o, trace_trap_o, trace_pc_rdata_o,
           trace_pc_wdata_o, trace_rd_addr_o, trace_rd_wdata_o
  );

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
           rvfi_rd_addr, rvfi_rd_wdata, trace_ready_i,
    input  trace_valid_o, trace_order_o, trace_insn_o, trace_trap_o, trace_pc_rdata_o,
           trace_pc_wdata_o, trace_rd_addr_o, trace_rd_wdata_o
  );
endinterface

// File: rtl/rvfi_trace_buffer.sv
// FWFT trace FIFO of retired-instruction records with sticky order/PC checks; record visible 1 cycle after capture.
// Never stalls the core: when full and not popping, records are dropped and counted.
module rvfi_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  rvfi_trace_buffer_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [CNT_W-1:0]         dropped_o,
  output logic                     order_err_o,
  output logic                     pc_err_o,
  input  logic                     err_clr_i
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } rec_t;

  rec_t             mem [DEPTH];
  rec_t             in_rec, head_q, head_n;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [PTR_W:0]   keep;
  logic             push, pop, drop, order_evt, pc_evt;
  logic [63:0]      exp_order;
  logic [31:0]      last_pc;
  logic             have_pc;

  assign in_rec = '{order:    bus.rvfi_order,    insn:     bus.rvfi_insn,
                    trap:     bus.rvfi_trap,     pc_rdata: bus.rvfi_pc_rdata,
                    pc_wdata: bus.rvfi_pc_wdata, rd_addr:  bus.rvfi_rd_addr,
                    rd_wdata: bus.rvfi_rd_wdata};

  assign pop       = (count_o != '0) && bus.trace_ready_i;
  assign push      = bus.rvfi_valid && ((count_o != CNT_FULL) || pop);
  assign drop      = bus.rvfi_valid && !push;
  assign order_evt = bus.rvfi_valid && (bus.rvfi_order != exp_order);
  assign pc_evt    = bus.rvfi_valid && have_pc && (bus.rvfi_pc_rdata != last_pc);
  assign rd_ptr_n  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign keep      = count_o - {{PTR_W{1'b0}}, pop};

  // Head is registered so the output fields have a defined reset value;
  // an empty-after-pop FIFO takes the incoming record straight into the head.
  always_comb begin
    head_n = head_q;
    if (keep != '0)
      head_n = mem[rd_ptr_n];
    else if (push)
      head_n = in_rec;
  end

  always_ff @(posedge clk_i) begin
    if (push && !rst_i)
      mem[wr_ptr] <= in_rec;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_o     <= '0;
      head_q      <= '0;
      overflow_o  <= 1'b0;
      dropped_o   <= '0;
      order_err_o <= 1'b0;
      pc_err_o    <= 1'b0;
      exp_order   <= '0;
      last_pc     <= '0;
      have_pc     <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_n;
      head_q <= head_n;
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase

      // New events take priority over a same-cycle clear.
      overflow_o  <= (overflow_o  && !err_clr_i) || drop;
      order_err_o <= (order_err_o && !err_clr_i) || order_evt;
      pc_err_o    <= (pc_err_o    && !err_clr_i) || pc_evt;
      if (drop) begin
        if (err_clr_i)
          dropped_o <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (dropped_o != '1)
          dropped_o <= dropped_o + 1'b1;
      end else if (err_clr_i) begin
        dropped_o <= '0;
      end

      if (bus.rvfi_valid) begin
        exp_order <= bus.rvfi_order + 64'd1;
        last_pc   <= bus.rvfi_pc_wdata;
        have_pc   <= 1'b1;
      end
    end
  end

  assign bus.trace_valid_o    = (count_o != '0);
  assign bus.trace_order_o    = head_q.order;
  assign bus.trace_insn_o     = head_q.insn;
  assign bus.trace_trap_o     = head_q.trap;
  assign bus.trace_pc_rdata_o = head_q.pc_rdata;
  assign bus.trace_pc_wdata_o = head_q.pc_wdata;
  assign bus.trace_rd_addr_o  = head_q.rd_addr;
  assign bus.trace_rd_wdata_o = head_q.rd_wdata;
endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Directed bench for rvfi_trace_buffer: capture, overflow/drop, streaming, order/PC checks, reset.
module tb_rvfi_trace_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        err_clr = 1'b0;
  logic [4:0]  count;
  logic        overflow, order_err, pc_err;
  logic [15:0] dropped;
  int          checks = 0;
  int          errors = 0;

  rvfi_trace_buffer_if bus();

  rvfi_trace_buffer #(.DEPTH(16), .CNT_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .count_o     (count),
    .overflow_o  (overflow),
    .dropped_o   (dropped),
    .order_err_o (order_err),
    .pc_err_o    (pc_err),
    .err_clr_i   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic retire(input logic [63:0] o, input logic [31:0] pc, input logic [31:0] npc,
                        input logic [31:0] insn, input logic trap, input logic [4:0] rd,
                        input logic [31:0] wd);
    bus.rvfi_valid    = 1'b1;
    bus.rvfi_order    = o;
    bus.rvfi_pc_rdata = pc;
    bus.rvfi_pc_wdata = npc;
    bus.rvfi_insn     = insn;
    bus.rvfi_trap     = trap;
    bus.rvfi_rd_addr  = rd;
    bus.rvfi_rd_wdata = wd;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rvfi_valid = 1'b0;
    bus.trace_ready_i = 1'b0;
    err_clr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.rvfi_valid = 1'b0;
    bus.rvfi_order = '0;
    bus.rvfi_insn = '0;
    bus.rvfi_trap = 1'b0;
    bus.rvfi_pc_rdata = '0;
    bus.rvfi_pc_wdata = '0;
    bus.rvfi_rd_addr = '0;
    bus.rvfi_rd_wdata = '0;
    bus.trace_ready_i = 1'b0;

    // Reset state
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_valid", bus.trace_valid_o, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_order_err", order_err, 0);
    chk("rst_pc_err", pc_err, 0);
    chk("rst_order_field", bus.trace_order_o, 0);
    chk("rst_insn_field", bus.trace_insn_o, 0);

    // Single retire into empty FIFO
    retire(64'd0, 32'h0, 32'h4, 32'h00500093, 1'b0, 5'd1, 32'd5);
    tick();
    bus.rvfi_valid = 1'b0;
    chk("single_valid", bus.trace_valid_o, 1);
    chk("single_order", bus.trace_order_o, 0);
    chk("single_insn", bus.trace_insn_o, 64'h00500093);
    chk("single_pc_rdata", bus.trace_pc_rdata_o, 0);
    chk("single_pc_wdata", bus.trace_pc_wdata_o, 4);
    chk("single_rd_addr", bus.trace_rd_addr_o, 1);
    chk("single_rd_wdata", bus.trace_rd_wdata_o, 5);
    chk("single_trap", bus.trace_trap_o, 0);
    chk("single_count", count, 1);
    chk("single_order_err", order_err, 0);
    chk("single_pc_err", pc_err, 0);
    chk("single_overflow", overflow, 0);

    // 20 retires, no consumer: 16 kept, 4 dropped
    do_reset();
    for (int i = 0; i < 20; i++) begin
      retire(64'(i), 32'(4*i), 32'(4*i+4), 32'(i), 1'b0, 5'(i), 32'(i));
      tick();
    end
    bus.rvfi_valid = 1'b0;
    chk("fill_count", count, 16);
    chk("fill_overflow", overflow, 1);
    chk("fill_dropped", dropped, 4);
    chk("fill_order_err", order_err, 0);
    chk("fill_pc_err", pc_err, 0);
    bus.trace_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", bus.trace_valid_o, 1);
      chk("drain_order", bus.trace_order_o, 64'(i));
      tick();
    end
    bus.trace_ready_i = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_valid_end", bus.trace_valid_o, 0);

    // Streaming with consumer always ready
    do_reset();
    bus.trace_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      retire(64'(i), 32'(4*i), 32'(4*i+4), 32'(i), 1'b0, 5'd2, 32'(i));
      tick();
      chk("stream_order", bus.trace_order_o, 64'(i));
      chk("stream_count", count, 1);
    end
    bus.rvfi_valid = 1'b0;
    tick();
    bus.trace_ready_i = 1'b0;
    chk("stream_count_end", count, 0);
    chk("stream_dropped", dropped, 0);
    chk("stream_overflow", overflow, 0);

    // Order gap: 0,1,3,4 then clear and feed 5
    do_reset();
    retire(64'd0, 32'h0, 32'h4, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    retire(64'd1, 32'h4, 32'h8, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    chk("gap_before", order_err, 0);
    retire(64'd3, 32'h8, 32'hC, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    chk("gap_set", order_err, 1);
    retire(64'd4, 32'hC, 32'h10, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    chk("gap_sticky", order_err, 1);
    bus.rvfi_valid = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("gap_cleared", order_err, 0);
    retire(64'd5, 32'h10, 32'h14, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    chk("gap_resync", order_err, 0);
    chk("gap_no_pc_err", pc_err, 0);
    // New error in the same cycle as a clear wins
    retire(64'd7, 32'h14, 32'h18, 32'h13, 1'b0, 5'd0, 32'd0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    bus.rvfi_valid = 1'b0;
    chk("gap_clr_collide", order_err, 1);

    // PC discontinuity, then trap redirect
    do_reset();
    retire(64'd0, 32'h0, 32'h4, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    chk("pc_first", pc_err, 0);
    retire(64'd1, 32'h8, 32'hC, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    chk("pc_jump", pc_err, 1);
    bus.rvfi_valid = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("pc_cleared", pc_err, 0);
    retire(64'd2, 32'hC, 32'h100, 32'h73, 1'b1, 5'd0, 32'd0); tick();
    retire(64'd3, 32'h100, 32'h104, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    bus.rvfi_valid = 1'b0;
    chk("pc_trap_ok", pc_err, 0);
    chk("pc_trap_order_err", order_err, 0);
    chk("pc_trap_field", bus.trace_trap_o, 0);
    chk("pc_count", count, 4);

    // Full FIFO: simultaneous push/pop, drops with clear, reset
    do_reset();
    for (int i = 0; i < 16; i++) begin
      retire(64'(i), 32'(4*i), 32'(4*i+4), 32'(i), 1'b0, 5'd3, 32'(i));
      tick();
    end
    chk("full_count", count, 16);
    retire(64'd16, 32'd64, 32'd68, 32'd16, 1'b0, 5'd3, 32'd16);
    bus.trace_ready_i = 1'b1;
    tick();
    bus.trace_ready_i = 1'b0;
    chk("full_pushpop_count", count, 16);
    chk("full_pushpop_dropped", dropped, 0);
    chk("full_pushpop_overflow", overflow, 0);
    chk("full_pushpop_head", bus.trace_order_o, 1);
    retire(64'd17, 32'd68, 32'd72, 32'd17, 1'b0, 5'd3, 32'd17); tick();
    chk("drop_one", dropped, 1);
    retire(64'd18, 32'd72, 32'd76, 32'd18, 1'b0, 5'd3, 32'd18);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("drop_clr_dropped", dropped, 1);
    chk("drop_clr_overflow", overflow, 1);
    retire(64'd99, 32'h500, 32'h504, 32'd0, 1'b0, 5'd3, 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    bus.rvfi_valid = 1'b0;
    chk("reset_count", count, 0);
    chk("reset_valid", bus.trace_valid_o, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_dropped", dropped, 0);
    chk("reset_order_err", order_err, 0);
    chk("reset_pc_err", pc_err, 0);
    retire(64'd0, 32'h200, 32'h204, 32'h13, 1'b0, 5'd0, 32'd0); tick();
    bus.rvfi_valid = 1'b0;
    chk("post_reset_order_err", order_err, 0);
    chk("post_reset_pc_err", pc_err, 0);
    chk("post_reset_order", bus.trace_order_o, 0);
    chk("post_reset_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rvfi_trace_buffer.md
# rvfi_trace_buffer

Retirement trace buffer and checker fed by the RVFI port of `dtcore32`. Each cycle `rvfi_valid` is high, it captures a compact record of the retired instruction into a first-word-fall-through FIFO. A downstream consumer (trace UART, debug host or testbench scoreboard) drains the FIFO through a valid/ready handshake. The block also runs two sticky, on-line consistency checks on the retirement stream: `rvfi_order` sequence and PC continuity.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of dropped-record counter.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `rvfi_valid`  in  1  instruction retired this cycle.
- `rvfi_order`  in  64  retirement index.
- `rvfi_insn`  in  32  instruction word.
- `rvfi_trap`  in  1  instruction trapped.
- `rvfi_pc_rdata`  in  32  PC of retired instruction.
- `rvfi_pc_wdata`  in  32  next PC.
- `rvfi_rd_addr`  in  5  destination register (0 = none).
- `rvfi_rd_wdata`  in  32  destination write data.
- `trace_valid_o`  out  1  head record available.
- `trace_ready_i`  in  1  consumer accepts head record.
- `trace_order_o`, `trace_insn_o`, `trace_trap_o`, `trace_pc_rdata_o`, `trace_pc_wdata_o`, `trace_rd_addr_o`, `trace_rd_wdata_o`  out  64/32/1/32/32/5/32  head record fields.
- `count_o`  out  $clog2(DEPTH)+1  entries held.
- `overflow_o`  out  1  sticky: at least one record dropped.
- `dropped_o`  out  CNT_W  dropped records, saturating at all-ones.
- `order_err_o`  out  1  sticky: `rvfi_order` discontinuity.
- `pc_err_o`  out  1  sticky: PC discontinuity.
- `err_clr_i`  in  1  clears `overflow_o`, `dropped_o`, `order_err_o` and `pc_err_o`.

## Operation
- Push: `rvfi_valid` high and (`count_o` < DEPTH or pop this cycle). The record is written at the tail.
- Pop: `trace_valid_o` and `trace_ready_i` both high. The head advances.
- Drop: `rvfi_valid` high, FIFO full and no pop. No write occurs. `overflow_o` is set and `dropped_o` increments (saturating).
- `trace_valid_o` = (`count_o` != 0). Output fields are the head entry. When `trace_valid_o` is low, the output fields hold the last head value and are don't-care.
- `count_o` update rules:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. Fullness is taken from `count_o`, not from pointer equality.
- Order check: register `exp_order` (64 b) resets to 0.
  - On every `rvfi_valid`, including dropped records: if `rvfi_order` != `exp_order`, set `order_err_o`.
  - Then `exp_order` ← `rvfi_order` + 1 (resynchronises so that only one error event is taken per gap).
- PC check: register `last_pc` plus flag `have_pc` (reset 0).
  - On `rvfi_valid` with `have_pc` = 1: if `rvfi_pc_rdata` != `last_pc`, set `pc_err_o`.
  - Then `last_pc` ← `rvfi_pc_wdata` and `have_pc` ← 1.
  - Trapped instructions are checked identically: `pc_wdata` is the handler address.
- `err_clr_i`: if asserted in the same cycle as a new error or drop, the new event wins. The flag ends set, and `dropped_o` = 1 if a drop occurred that cycle.
- Reset values: pointers 0, `count_o` 0, `trace_valid_o` 0, all sticky flags 0, `dropped_o` 0, `exp_order` 0, `have_pc` 0, output fields 0. Reset mid-stream discards all buffered records. FIFO storage need not be cleared.

## Timing
- Push-to-visible latency is 1 cycle. A record captured at edge N is on `trace_*_o` with `trace_valid_o` = 1 after edge N (when the FIFO was empty).
- Full throughput: one push and one pop per cycle sustained, with no bubbles.
- `trace_ready_i` may be high while `trace_valid_o` is low; this has no effect.
- Sticky flags and `dropped_o` update at the edge that samples the offending `rvfi_valid`.
- `rst_i` overrides all other inputs in the same cycle.

## Test plan
- Single retire (order 0, pc 0x0→0x4, insn 0x00500093, rd 1, wdata 5) into empty FIFO, `trace_ready_i` = 0 → next cycle `trace_valid_o` = 1, fields match, `count_o` = 1, all error flags 0.
- 20 consecutive retires (orders 0..19, contiguous PCs) with `trace_ready_i` = 0, DEPTH = 16 → `count_o` = 16, `overflow_o` = 1, `dropped_o` = 4. Draining yields orders 0..15 in sequence. No order or pc error.
- Continuous retire with `trace_ready_i` = 1 for 40 cycles → `count_o` never exceeds 1, output orders 0..39 in sequence, pointers wrap twice, no drops.
- Orders 0, 1, 3, 4 → `order_err_o` set at the edge sampling order 3 and remains set. Order 4 raises no additional event (verify via clear-then-feed order 5 → stays 0).
- PC sequence 0x0→0x4, then retire with `pc_rdata` 0x8 → `pc_err_o` = 1. A trap at 0xC with `pc_wdata` 0x100 followed by `pc_rdata` 0x100 → no new error after `err_clr_i`.
- FIFO full, simultaneous push and pop → `count_o` stays 16, no drop. Then assert `rst_i` with 16 entries → next cycle `count_o` = 0, `trace_valid_o` = 0, all flags 0, and the next retire must use order 0.
